// File: rtl/button_pkg.sv
// rtl/button_pkg.sv - shared types and constants for the button event arbiter
package button_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    OFFER = 1'b1
  } state_e;

  localparam logic EVT_PRESS = 1'b0;
  localparam logic EVT_LONG  = 1'b1;

  // 1 s at 100 MHz
  localparam int HOLD_CYCLES_DEFAULT = 100_000_000;

endpackage

// File: rtl/hold_timer.sv
// rtl/hold_timer.sv - per-button hold counter, one long_evt strobe per continuous hold
module hold_timer
  import button_pkg::*;
#(
  parameter int HOLD_CYCLES = HOLD_CYCLES_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic level,
  output logic long_evt
);

  localparam int CW = $clog2(HOLD_CYCLES + 1);
  localparam logic [CW-1:0] MAX_CNT = CW'(HOLD_CYCLES);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (!level) begin
      cnt_d = '0;
    end else if (cnt_q != MAX_CNT) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Fires only on the step into saturation, so a held button yields one event.
  assign long_evt = level && (cnt_q == MAX_CNT - CW'(1));

endmodule

// File: rtl/button_event_arbiter.sv
// rtl/button_event_arbiter.sv - round-robin arbiter queuing press/long-hold events per button
module button_event_arbiter
  import button_pkg::*;
#(
  parameter  int N           = 4,
  parameter  int HOLD_CYCLES = HOLD_CYCLES_DEFAULT,
  localparam int IDW         = $clog2(N)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N-1:0]   btn_pulse,
  input  logic [N-1:0]   btn_level,
  input  logic           evt_ready,
  input  logic           clr_overflow,
  output logic           evt_valid,
  output logic [IDW-1:0] evt_id,
  output logic           evt_long,
  output logic           overflow
);

  state_e         state_q;
  logic [N-1:0]   press_pend_q, press_pend_d;
  logic [N-1:0]   long_pend_q, long_pend_d;
  logic [N-1:0]   long_evt;
  logic [N-1:0]   grant_press, grant_long, lost;
  logic [IDW-1:0] rr_ptr_q, rr_ptr_next;
  logic           evt_valid_q, evt_long_q, overflow_q, overflow_d;
  logic [IDW-1:0] evt_id_q;
  logic           pick_found;
  logic [IDW-1:0] pick_idx;

  for (genvar g = 0; g < N; g++) begin : g_hold
    hold_timer #(.HOLD_CYCLES(HOLD_CYCLES)) u_hold (
      .clk      (clk),
      .rst      (rst),
      .level    (btn_level[g]),
      .long_evt (long_evt[g])
    );
  end

  // First pending index at or after ptr, wrapping explicitly at N.
  function automatic logic [IDW:0] rr_pick(input logic [N-1:0] pend, input logic [IDW-1:0] ptr);
    logic [IDW:0]   res;
    logic [IDW-1:0] idx;
    int             j;
    res = '0;
    for (int k = N - 1; k >= 0; k--) begin
      j = int'(ptr) + k;
      if (j >= N) j = j - N;
      idx = IDW'(j);
      if (pend[idx]) res = {1'b1, idx};
    end
    return res;
  endfunction

  always_comb begin
    {pick_found, pick_idx} = rr_pick(press_pend_q | long_pend_q, rr_ptr_q);
  end

  assign rr_ptr_next = (pick_idx == IDW'(N - 1)) ? '0 : pick_idx + IDW'(1);

  always_comb begin
    grant_press = '0;
    grant_long  = '0;
    if (state_q == IDLE && pick_found) begin
      if (press_pend_q[pick_idx]) grant_press[pick_idx] = 1'b1;
      else                        grant_long[pick_idx]  = 1'b1;
    end
  end

  // A pulse only counts as lost when its pending slot stays occupied.
  assign lost         = btn_pulse & press_pend_q & ~grant_press;
  assign press_pend_d = (press_pend_q & ~grant_press) | btn_pulse;
  assign long_pend_d  = (long_pend_q & ~grant_long) | long_evt;
  assign overflow_d   = (|lost) | (overflow_q & ~clr_overflow);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      press_pend_q <= '0;
      long_pend_q  <= '0;
      rr_ptr_q     <= '0;
      evt_valid_q  <= 1'b0;
      evt_id_q     <= '0;
      evt_long_q   <= EVT_PRESS;
      overflow_q   <= 1'b0;
    end else begin
      press_pend_q <= press_pend_d;
      long_pend_q  <= long_pend_d;
      overflow_q   <= overflow_d;
      case (state_q)
        IDLE: begin
          if (pick_found) begin
            evt_id_q    <= pick_idx;
            evt_long_q  <= press_pend_q[pick_idx] ? EVT_PRESS : EVT_LONG;
            evt_valid_q <= 1'b1;
            rr_ptr_q    <= rr_ptr_next;
            state_q     <= OFFER;
          end
        end
        OFFER: begin
          if (evt_ready) begin
            evt_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign evt_valid = evt_valid_q;
  assign evt_id    = evt_id_q;
  assign evt_long  = evt_long_q;
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_button_event_arbiter.sv
// tb/tb_button_event_arbiter.sv - directed self-checking bench for button_event_arbiter
module tb_button_event_arbiter;

  logic       clk;
  logic       rst;
  logic [3:0] btn_pulse;
  logic [3:0] btn_level;
  logic       evt_ready;
  logic       clr_overflow;
  logic       evt_valid;
  logic [1:0] evt_id;
  logic       evt_long;
  logic       overflow;

  int checks = 0;
  int errors = 0;
  logic flag;

  button_event_arbiter #(.N(4), .HOLD_CYCLES(8)) dut (
    .clk          (clk),
    .rst          (rst),
    .btn_pulse    (btn_pulse),
    .btn_level    (btn_level),
    .evt_ready    (evt_ready),
    .clr_overflow (clr_overflow),
    .evt_valid    (evt_valid),
    .evt_id       (evt_id),
    .evt_long     (evt_long),
    .overflow     (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_evt(input string tag, input logic [1:0] id, input logic lng);
    chk({tag, "_valid"}, 32'(evt_valid), 32'd1);
    chk({tag, "_id"}, 32'(evt_id), 32'(id));
    chk({tag, "_long"}, 32'(evt_long), 32'(lng));
  endtask

  initial begin
    rst = 1'b0; btn_pulse = '0; btn_level = '0; evt_ready = 1'b0; clr_overflow = 1'b0;
    #1;
    chk("rst_valid", 32'(evt_valid), 32'd0);
    chk("rst_id", 32'(evt_id), 32'd0);
    chk("rst_long", 32'(evt_long), 32'd0);
    chk("rst_ovf", 32'(overflow), 32'd0);
    tick(); tick();
    rst = 1'b1;

    // single press, no contention: valid two edges after the pulse
    evt_ready = 1'b1;
    btn_pulse = 4'b0010; tick(); btn_pulse = '0;
    chk("t1_lat1", 32'(evt_valid), 32'd0);
    tick(); chk_evt("t1_evt", 2'd1, 1'b0);
    tick(); chk("t1_drop", 32'(evt_valid), 32'd0);

    // all four at once from rr_ptr=0
    rst = 1'b0; tick(); rst = 1'b1;
    btn_pulse = 4'b1111; tick(); btn_pulse = '0;
    for (int k = 0; k < 4; k++) begin
      tick(); chk_evt($sformatf("t2_evt%0d", k), 2'(k), 1'b0);
      tick(); chk($sformatf("t2_gap%0d", k), 32'(evt_valid), 32'd0);
    end
    chk("t2_ovf", 32'(overflow), 32'd0);

    // back-pressure, overflow and clear
    evt_ready = 1'b0;
    btn_pulse = 4'b0100; tick(); btn_pulse = '0;
    tick(); chk_evt("t3_offer", 2'd2, 1'b0);
    flag = 1'b1;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (!(evt_valid === 1'b1 && evt_id === 2'd2 && evt_long === 1'b0)) flag = 1'b0;
    end
    chk("t3_stable", 32'(flag), 32'd1);
    btn_pulse = 4'b0100; tick(); btn_pulse = '0;
    chk("t3_pend_noovf", 32'(overflow), 32'd0);
    btn_pulse = 4'b0100; tick(); btn_pulse = '0;
    chk("t3_ovf_set", 32'(overflow), 32'd1);
    tick(); chk("t3_ovf_sticky", 32'(overflow), 32'd1);
    clr_overflow = 1'b1; tick(); clr_overflow = 1'b0;
    chk("t3_ovf_clr", 32'(overflow), 32'd0);
    evt_ready = 1'b1;
    tick(); chk("t3_hs1", 32'(evt_valid), 32'd0);
    tick(); chk_evt("t3_evt2", 2'd2, 1'b0);
    tick(); chk("t3_hs2", 32'(evt_valid), 32'd0);
    tick(); chk("t3_empty", 32'(evt_valid), 32'd0);

    // press then exactly one long hold on button 3
    btn_level = 4'b1000; btn_pulse = 4'b1000; tick(); btn_pulse = '0;
    tick(); chk_evt("t4_press", 2'd3, 1'b0);
    tick(); chk("t4_press_hs", 32'(evt_valid), 32'd0);
    flag = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick();
      if (evt_valid !== 1'b0) flag = 1'b1;
    end
    chk("t4_early", 32'(flag), 32'd0);
    tick(); chk_evt("t4_long", 2'd3, 1'b1);
    tick(); chk("t4_long_hs", 32'(evt_valid), 32'd0);
    flag = 1'b0;
    for (int k = 0; k < 40; k++) begin
      tick();
      if (evt_valid !== 1'b0) flag = 1'b1;
    end
    chk("t4_no_more", 32'(flag), 32'd0);
    btn_level = '0; tick(); tick(); tick();
    chk("t4_release", 32'(evt_valid), 32'd0);
    chk("t4_ovf", 32'(overflow), 32'd0);

    // async reset mid-offer with pending events
    evt_ready = 1'b0;
    btn_pulse = 4'b1111; tick(); btn_pulse = '0;
    tick(); chk_evt("t5_offer", 2'd0, 1'b0);
    #2 rst = 1'b0;
    #1 chk("t5_async_valid", 32'(evt_valid), 32'd0);
    chk("t5_async_id", 32'(evt_id), 32'd0);
    tick(); rst = 1'b1; evt_ready = 1'b1;
    flag = 1'b0;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (evt_valid !== 1'b0) flag = 1'b1;
    end
    chk("t5_no_stale", 32'(flag), 32'd0);

    // pulse during its own grant cycle keeps the pending bit, no overflow
    btn_pulse = 4'b0001; tick();
    tick(); btn_pulse = '0;
    chk_evt("t6_first", 2'd0, 1'b0);
    chk("t6_ovf", 32'(overflow), 32'd0);
    tick(); chk("t6_hs", 32'(evt_valid), 32'd0);
    tick(); chk_evt("t6_second", 2'd0, 1'b0);
    tick(); chk("t6_hs2", 32'(evt_valid), 32'd0);
    chk("t6_ovf_end", 32'(overflow), 32'd0);

    // clear and new overflow in the same cycle: set wins
    evt_ready = 1'b0;
    btn_pulse = 4'b0001; tick(); btn_pulse = '0;
    tick();
    btn_pulse = 4'b0001; tick();
    clr_overflow = 1'b1; tick(); btn_pulse = '0; clr_overflow = 1'b0;
    chk("t7_set_wins", 32'(overflow), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/button_event_arbiter.md
Name: button_event_arbiter

Overview:
Collects press pulses and debounced levels from N pushbutton_detector channels. Classifies each button activity as a short press or a long hold. Queues one pending event per type per button and hands events one at a time to a downstream consumer over a valid/ready handshake, using round-robin arbitration. Sits between the per-button detectors and the application FSM that consumes button commands.

Parameters:
N, 4, number of button channels (N >= 2)
HOLD_CYCLES, 100000000, clk cycles btn_level must stay high to raise a long-hold event (1 s at 100 MHz)
IDW, $clog2(N), width of evt_id (derived; not to be overridden)

Ports:
clk  input  1  system clock; all inputs synchronous to it
rst  input  1  asynchronous reset, active-low
btn_pulse  input  N  single-cycle press pulses, one per button
btn_level  input  N  debounced, synchronised button levels
evt_ready  input  1  consumer accepts the current event
clr_overflow  input  1  clears the overflow flag
evt_valid  output  1  event presented
evt_id  output  IDW  index of the button that produced the event
evt_long  output  1  0 = press event, 1 = long-hold event
overflow  output  1  sticky flag: a press event was lost

Behaviour:
- Reset (rst=0, immediate):
  - Outputs: evt_valid=0, evt_id=0, evt_long=0, overflow=0.
  - Internal: press_pend=0, long_pend=0, all hold counters=0, rr_ptr=0, state=IDLE.
- Press capture:
  - btn_pulse[i]=1 in cycle t sets press_pend[i] at t+1.
  - If press_pend[i] is already set and is not being granted in cycle t, the new pulse is dropped and overflow is set at t+1.
  - If press_pend[i] is granted in the same cycle as a new pulse, press_pend[i] stays set and overflow is not raised.
- Hold timer, per button:
  - The counter increments while btn_level[i]=1, saturates at HOLD_CYCLES, and clears to 0 in the cycle after btn_level[i]=0.
  - On the transition to HOLD_CYCLES, long_pend[i] is set exactly once per continuous hold.
  - A second long event while long_pend[i] is still set is merged silently and does not raise overflow.
- FSM states: IDLE, OFFER.
  - IDLE, no pending bits: stay in IDLE, evt_valid=0.
  - IDLE, any (press_pend | long_pend) set: scan indices rr_ptr, rr_ptr+1, … with wrap at N, and take the first index i with a pending bit.
    - Press takes priority over long for the same i.
    - Register evt_id=i and evt_long (0 for press, 1 for long).
    - Clear the granted pending bit.
    - Set evt_valid=1 and rr_ptr=(i+1) mod N.
    - Next state = OFFER.
  - OFFER: evt_valid, evt_id and evt_long are held stable. When evt_valid & evt_ready, next cycle evt_valid=0 and state returns to IDLE.
- Latency and throughput:
  - A pulse in cycle t gives pend at t+1 and evt_valid at t+2 (IDLE, no contention).
  - Maximum throughput is one event per 2 cycles.
- evt_valid must never drop without a handshake, except on reset.
- overflow is sticky until clr_overflow=1. If clr_overflow and a new overflow occur in the same cycle, set wins.
- Reset asserted mid-OFFER discards the offered event and all pending events. No stale event appears after release.
- Widths: hold counter width is $clog2(HOLD_CYCLES+1). rr_ptr is IDW bits, and its wrap is explicit (mod N, correct for non-power-of-2 N).

Decomposition:
- Shared package button_pkg:
  - state enum {IDLE, OFFER}
  - EVT_PRESS=1'b0, EVT_LONG=1'b1
  - default HOLD_CYCLES constant
- Sub-module hold_timer (parameter HOLD_CYCLES; ports clk, rst, level, long_evt): instantiated N times via generate.
- Round-robin pick: a function inside the arbiter. No separate module.

Test Plan:
1. N=4, HOLD_CYCLES=8, evt_ready=1; btn_pulse[1] at cycle 10 -> evt_valid=1 at cycle 12 with evt_id=1, evt_long=0; evt_valid=0 at cycle 13.
2. btn_pulse=4'b1111 in one cycle, rr_ptr=0, evt_ready=1 -> events evt_id 0,1,2,3, evt_long=0, spaced 2 cycles apart; overflow=0.
3. evt_ready=0:
   - Pulse btn 2: event offered and held stable for 20 cycles.
   - Pulse btn 2 again: press_pend set.
   - Third pulse on btn 2: overflow=1.
   - clr_overflow: overflow=0.
   - Raise evt_ready: two id=2 press events delivered.
4. btn_level[3] high for 50 cycles with btn_pulse[3] at its first cycle -> one press event (id 3, long 0), then exactly one long event (id 3, long 1) about 8 cycles after the rise; no further events.
5. rst driven low while evt_valid=1 and 3 events pending -> evt_valid=0 with no clk edge; after release with idle inputs, evt_valid stays 0 for 20 cycles.
6. With btn 0 granted (IDLE->OFFER cycle), a new btn_pulse[0] in the same cycle -> overflow stays 0 and a second id=0 press event follows the first handshake.
